// File: rtl/instr_pkg.sv
// Shared opcode, command, field-layout, FSM-state and error-bit definitions for instr_decode.
package instr_pkg;

  localparam int unsigned INSTR_W  = 64;
  localparam int unsigned FIELDS_W = 56;
  localparam int unsigned OPC_W    = 8;
  localparam int unsigned OPC_LSB  = 56;
  localparam int unsigned EXT_W    = 32;
  localparam int unsigned EXT_LSB  = 24;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned LEN_LSB  = 16;
  localparam int unsigned SEL_LSB  = 8;
  localparam int unsigned FLG_LSB  = 0;
  localparam int unsigned CMD_OP_W = 3;
  localparam int unsigned ERR_W    = 3;

  localparam logic [OPC_W-1:0] OP_NOP          = 8'h00;
  localparam logic [OPC_W-1:0] OP_LOAD_FEATURE = 8'h04;
  localparam logic [OPC_W-1:0] OP_LOAD_WEIGHT  = 8'h05;
  localparam logic [OPC_W-1:0] OP_CONV         = 8'h06;
  localparam logic [OPC_W-1:0] OP_STORE        = 8'h07;
  localparam logic [OPC_W-1:0] OP_END          = 8'hFF;

  localparam logic [CMD_OP_W-1:0] CMD_NOP          = 3'd0;
  localparam logic [CMD_OP_W-1:0] CMD_LOAD_FEATURE = 3'd1;
  localparam logic [CMD_OP_W-1:0] CMD_LOAD_WEIGHT  = 3'd2;
  localparam logic [CMD_OP_W-1:0] CMD_CONV         = 3'd3;
  localparam logic [CMD_OP_W-1:0] CMD_STORE        = 3'd4;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_ADDR = 1;
  localparam int unsigned ERR_OPC  = 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH_WAIT, ST_DECODE, ST_ISSUE, ST_WAIT_DONE, ST_HALT
  } state_e;

  typedef struct packed {
    logic [CMD_OP_W-1:0] op;
    logic [EXT_W-1:0]    ext_addr;
    logic [BYTE_W-1:0]   len;
    logic [BYTE_W-1:0]   mem_sel;
    logic [BYTE_W-1:0]   flags;
  } cmd_t;

  function automatic logic [CMD_OP_W-1:0] cmd_op_of(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_LOAD_FEATURE: return CMD_LOAD_FEATURE;
      OP_LOAD_WEIGHT:  return CMD_LOAD_WEIGHT;
      OP_CONV:         return CMD_CONV;
      OP_STORE:        return CMD_STORE;
      default:         return CMD_NOP;
    endcase
  endfunction

  function automatic cmd_t make_cmd(input logic [FIELDS_W-1:0] w, input logic [CMD_OP_W-1:0] op);
    cmd_t c;
    c.op       = op;
    c.ext_addr = w[EXT_LSB +: EXT_W];
    c.len      = w[LEN_LSB +: BYTE_W];
    c.mem_sel  = w[SEL_LSB +: BYTE_W];
    c.flags    = w[FLG_LSB +: BYTE_W];
    return c;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x WIDTH instruction FIFO; extra pointer bit separates full from empty.
module instr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = PW + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]    waddr;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign rd_en   = pop && !empty_c && !flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push && (flush || !full_c || rd_en);
  assign waddr   = flush ? '0 : wptr_q[PW-1:0];
  assign rdata_c = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = wr_en ? PTR_W'(1) : '0;
    end else begin
      if (rd_en) rptr_d = rptr_q + PTR_W'(1);
      if (wr_en) wptr_d = wptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= wdata;
  end

endmodule

// File: rtl/instr_decode.sv
// Instruction decoder: buffers fetched words, decodes them and issues one command at a time.
// Optional INSTR_DECODE_STATS_EN adds decoded-word and busy-cycle counters.
module instr_decode
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_fetch_enable,
  input  logic [INSTR_W-1:0]  i_instr,
  input  logic [AW-1:0]       i_instr_addr,
  input  logic                i_instr_enable,
  output logic                o_cmd_valid,
  input  logic                i_cmd_ready,
  output logic [CMD_OP_W-1:0] o_cmd_op,
  output logic [EXT_W-1:0]    o_cmd_ext_addr,
  output logic [BYTE_W-1:0]   o_cmd_len,
  output logic [BYTE_W-1:0]   o_cmd_mem_sel,
  output logic [BYTE_W-1:0]   o_cmd_flags,
  input  logic                i_exec_done,
  output logic                o_busy,
  output logic                o_done,
  output logic [ERR_W-1:0]    o_err
`ifdef INSTR_DECODE_STATS_EN
  ,
  output logic [15:0]         o_stat_instr,
  output logic [31:0]         o_stat_cycles
`endif
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  cmd_t               cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               fetch_en_q, fetch_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_pend_q, done_pend_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [AW-1:0]      exp_addr_q, exp_addr_d, exp_base;

  logic               start_acc, pop;
  logic               fifo_full_c, fifo_empty_c;
  logic [INSTR_W-1:0] fifo_rdata_c;
  logic [OPC_W-1:0]   opcode;

  assign start_acc = i_start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign pop       = (state_q == ST_FETCH_WAIT) && !fifo_empty_c;
  assign opcode    = instr_q[OPC_LSB +: OPC_W];

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (start_acc),
    .push    (i_instr_enable),
    .pop     (pop),
    .wdata   (i_instr),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    fetch_en_d  = 1'b0;
    done_d      = done_q;
    done_pend_d = done_pend_q;
    err_d       = err_q;
    exp_base    = start_acc ? '0 : exp_addr_q;
    exp_addr_d  = exp_base;

    if (start_acc) begin
      fetch_en_d = 1'b1;
      done_d     = 1'b0;
      err_d      = '0;
    end

    // Write-side checks; a start flushes the FIFO so it can never overflow that cycle.
    if (i_instr_enable) begin
      exp_addr_d = exp_base + AW'(1);
      if (i_instr_addr != exp_base) err_d[ERR_ADDR] = 1'b1;
      if (fifo_full_c && !pop && !start_acc) err_d[ERR_OVF] = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_acc) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        if (pop) begin
          instr_d = fifo_rdata_c;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_END: begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end
          OP_NOP: state_d = ST_FETCH_WAIT;
          OP_LOAD_FEATURE, OP_LOAD_WEIGHT, OP_CONV, OP_STORE: begin
            cmd_d       = make_cmd(instr_q[FIELDS_W-1:0], cmd_op_of(opcode));
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
          default: begin
            err_d[ERR_OPC] = 1'b1;
            done_d         = 1'b1;
            state_d        = ST_HALT;
          end
        endcase
      end
      ST_ISSUE: begin
        // A completion coinciding with the handshake is remembered for WAIT_DONE.
        if (i_cmd_ready) begin
          cmd_valid_d = 1'b0;
          done_pend_d = i_exec_done;
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_exec_done || done_pend_q) begin
          done_pend_d = 1'b0;
          state_d     = ST_FETCH_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_HALT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      fetch_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
      err_q       <= '0;
      exp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      fetch_en_q  <= fetch_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_pend_q <= done_pend_d;
      err_q       <= err_d;
      exp_addr_q  <= exp_addr_d;
    end
  end

  assign o_fetch_enable = fetch_en_q;
  assign o_cmd_valid    = cmd_valid_q;
  assign o_cmd_op       = cmd_q.op;
  assign o_cmd_ext_addr = cmd_q.ext_addr;
  assign o_cmd_len      = cmd_q.len;
  assign o_cmd_mem_sel  = cmd_q.mem_sel;
  assign o_cmd_flags    = cmd_q.flags;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

`ifdef INSTR_DECODE_STATS_EN
  localparam int unsigned STAT_INSTR_W = 16;
  localparam int unsigned STAT_CYC_W   = 32;

  logic [STAT_INSTR_W-1:0] stat_instr_q, stat_instr_d;
  logic [STAT_CYC_W-1:0]   stat_cyc_q, stat_cyc_d;

  // Saturating counters, cleared whenever a program starts.
  always_comb begin
    stat_instr_d = stat_instr_q;
    stat_cyc_d   = stat_cyc_q;
    if (start_acc) begin
      stat_instr_d = '0;
      stat_cyc_d   = '0;
    end else begin
      if ((state_q == ST_DECODE) && !(&stat_instr_q))
        stat_instr_d = stat_instr_q + STAT_INSTR_W'(1);
      if ((state_q != ST_IDLE) && (state_q != ST_HALT) && !(&stat_cyc_q))
        stat_cyc_d = stat_cyc_q + STAT_CYC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_instr_q <= '0;
      stat_cyc_q   <= '0;
    end else begin
      stat_instr_q <= stat_instr_d;
      stat_cyc_q   <= stat_cyc_d;
    end
  end

  assign o_stat_instr  = stat_instr_q;
  assign o_stat_cycles = stat_cyc_q;
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: expected commands are queued at push time
// and compared when the DUT presents them on the command interface.
module tb_instr_decode;

  localparam int unsigned AW = 5;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] ext;
    logic [7:0]  len;
    logic [7:0]  sel;
    logic [7:0]  flg;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          o_fetch_enable;
  logic [63:0]   i_instr;
  logic [AW-1:0] i_instr_addr;
  logic          i_instr_enable;
  logic          o_cmd_valid;
  logic          i_cmd_ready;
  logic [2:0]    o_cmd_op;
  logic [31:0]   o_cmd_ext_addr;
  logic [7:0]    o_cmd_len;
  logic [7:0]    o_cmd_mem_sel;
  logic [7:0]    o_cmd_flags;
  logic          i_exec_done;
  logic          o_busy;
  logic          o_done;
  logic [2:0]    o_err;
`ifdef INSTR_DECODE_STATS_EN
  logic [15:0]   o_stat_instr;
  logic [31:0]   o_stat_cycles;
`endif

  exp_t sb[$];
  exp_t e;
  exp_t got;
  int   checks;
  int   failures;
  bit   ok;
  logic seen;

  instr_decode #(.DEPTH(16), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .o_fetch_enable (o_fetch_enable),
    .i_instr        (i_instr),
    .i_instr_addr   (i_instr_addr),
    .i_instr_enable (i_instr_enable),
    .o_cmd_valid    (o_cmd_valid),
    .i_cmd_ready    (i_cmd_ready),
    .o_cmd_op       (o_cmd_op),
    .o_cmd_ext_addr (o_cmd_ext_addr),
    .o_cmd_len      (o_cmd_len),
    .o_cmd_mem_sel  (o_cmd_mem_sel),
    .o_cmd_flags    (o_cmd_flags),
    .i_exec_done    (i_exec_done),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
`ifdef INSTR_DECODE_STATS_EN
    ,
    .o_stat_instr   (o_stat_instr),
    .o_stat_cycles  (o_stat_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [63:0] w);
    exp_t r;
    case (w[63:56])
      8'h04:   r.op = 3'd1;
      8'h05:   r.op = 3'd2;
      8'h06:   r.op = 3'd3;
      8'h07:   r.op = 3'd4;
      default: r.op = 3'd0;
    endcase
    r.ext = w[55:24];
    r.len = w[23:16];
    r.sel = w[15:8];
    r.flg = w[7:0];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [63:0] w, input logic [AW-1:0] a, input bit expect_cmd);
    if (expect_cmd) sb.push_back(mk(w));
    i_instr        = w;
    i_instr_addr   = a;
    i_instr_enable = 1'b1;
    tick;
    i_instr_enable = 1'b0;
  endtask

  task automatic start_prog;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_cmd_valid) begin
        found = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic wait_halt(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_done) begin
        found = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic finish_cmd;
    tick;
    i_exec_done = 1'b1;
    tick;
    i_exec_done = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({o_fetch_enable, o_cmd_valid, o_busy, o_done, o_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {o_fetch_enable, o_cmd_valid, o_busy, o_done, o_err});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({o_cmd_op, o_cmd_ext_addr, o_cmd_len, o_cmd_mem_sel, o_cmd_flags, o_busy, o_done} !== '0) begin
      failures++;
      $display("FAIL reset_fields op=%0d ext=%h busy=%b done=%b", o_cmd_op, o_cmd_ext_addr, o_busy, o_done);
    end
  endtask

  task automatic test_basic;
    start_prog;
    checks++;
    if (o_fetch_enable !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse fetch=%b busy=%b exp=1/1", o_fetch_enable, o_busy);
    end
    push_w(64'h0400000000010100, 5'd0, 1'b1);
    checks++;
    if (o_fetch_enable !== 1'b0 || o_cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL pulse_len fetch=%b valid=%b exp=0/0", o_fetch_enable, o_cmd_valid);
    end
    tick;
    checks++;
    if (o_cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early valid=%b exp=0", o_cmd_valid);
    end
    tick;
    got = {o_cmd_op, o_cmd_ext_addr, o_cmd_len, o_cmd_mem_sel, o_cmd_flags};
    checks++;
    if (o_cmd_valid !== 1'b1 || got !== {3'd1, 32'd0, 8'd1, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL basic_cmd valid=%b got=%h exp=%h", o_cmd_valid, got, {3'd1, 32'd0, 8'd1, 8'd1, 8'd0});
    end
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL basic_sb got=%h exp=%h", got, e);
    end
    tick;
    checks++;
    if (o_cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_drop got=%b exp=0", o_cmd_valid);
    end
    i_exec_done = 1'b1;
    tick;
    i_exec_done = 1'b0;
    push_w(64'hFF00000000000000, 5'd1, 1'b0);
    wait_halt(ok);
    checks++;
    if (!ok || o_err !== 3'b000 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end done=%b err=%b busy=%b exp=1/000/0", ok, o_err, o_busy);
    end
`ifdef INSTR_DECODE_STATS_EN
    checks++;
    if (o_stat_instr !== 16'd2) begin
      failures++;
      $display("FAIL basic_stat got=%0d exp=2", o_stat_instr);
    end
`endif
  endtask

  task automatic test_overflow;
    logic [63:0] w;
    start_prog;
    push_w(64'h05000010000402AA, 5'd0, 1'b1);
    wait_valid(ok);
    got = {o_cmd_op, o_cmd_ext_addr, o_cmd_len, o_cmd_mem_sel, o_cmd_flags};
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      failures++;
      $display("FAIL ovf_first found=%b got=%h exp=%h", ok, got, e);
    end
    tick;
    for (int i = 0; i < 17; i++) begin
      w = {8'(4 + i % 4), 32'(32'hA0000000 + i), 8'(i + 1), 8'(i), 8'(8'hF0 | i)};
      push_w(w, AW'(i + 1), i < 16);
      if (i == 15) begin
        checks++;
        if (o_err !== 3'b000) begin
          failures++;
          $display("FAIL ovf_early err=%b exp=000", o_err);
        end
      end
    end
    checks++;
    if (o_err !== 3'b001) begin
      failures++;
      $display("FAIL ovf_flag err=%b exp=001", o_err);
    end
    i_exec_done = 1'b1;
    tick;
    i_exec_done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++;
        $display("FAIL ovf_timeout idx=%0d found=%b pending=%0d", k, ok, sb.size());
        break;
      end
      got = {o_cmd_op, o_cmd_ext_addr, o_cmd_len, o_cmd_mem_sel, o_cmd_flags};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL ovf_order idx=%0d got=%h exp=%h", k, got, e);
      end
      finish_cmd;
    end
    push_w(64'hFF00000000000000, 5'd18, 1'b0);
    wait_halt(ok);
    checks++;
    if (!ok || o_err !== 3'b001 || sb.size() != 0) begin
      failures++;
      $display("FAIL ovf_end done=%b err=%b pending=%0d exp=1/001/0", ok, o_err, sb.size());
    end
  endtask

  task automatic test_addr_seq;
    logic [AW-1:0] addrs [3];
    logic [63:0]   words [3];
    addrs[0] = 5'd0; addrs[1] = 5'd1; addrs[2] = 5'd3;
    words[0] = 64'h0400000100020311;
    words[1] = 64'h0600000200040522;
    words[2] = 64'h07DEADBEEF080633;
    i_cmd_ready = 1'b0;
    start_prog;
    for (int i = 0; i < 3; i++) begin
      push_w(words[i], addrs[i], 1'b1);
      checks++;
      if (o_err !== ((i == 2) ? 3'b010 : 3'b000)) begin
        failures++;
        $display("FAIL addr_err push=%0d err=%b exp=%b", i, o_err, (i == 2) ? 3'b010 : 3'b000);
      end
    end
    i_cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++;
        $display("FAIL addr_timeout idx=%0d found=%b", k, ok);
        break;
      end
      got = {o_cmd_op, o_cmd_ext_addr, o_cmd_len, o_cmd_mem_sel, o_cmd_flags};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL addr_cmd idx=%0d got=%h exp=%h", k, got, e);
      end
      finish_cmd;
    end
    push_w(64'hFF00000000000000, 5'd3, 1'b0);
    wait_halt(ok);
    checks++;
    if (!ok || o_err !== 3'b010) begin
      failures++;
      $display("FAIL addr_end done=%b err=%b exp=1/010", ok, o_err);
    end
  endtask

  task automatic test_illegal;
    start_prog;
    push_w(64'h9A00000000000000, 5'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | o_cmd_valid;
      tick;
    end
    checks++;
    if (seen !== 1'b0 || o_err !== 3'b100 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal valid_seen=%b err=%b busy=%b exp=0/100/0", seen, o_err, o_busy);
    end
  endtask

  task automatic test_back_to_back;
    i_cmd_ready = 1'b0;
    start_prog;
    push_w(64'h061234567820035A, 5'd0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout found=%b exp=1", ok);
    end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      got = {o_cmd_op, o_cmd_ext_addr, o_cmd_len, o_cmd_mem_sel, o_cmd_flags};
      checks++;
      if (o_cmd_valid !== 1'b1 || got !== e) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b got=%h exp=%h", k, o_cmd_valid, got, e);
      end
      tick;
    end
    i_cmd_ready = 1'b1;
    i_exec_done = 1'b1;
    tick;
    i_exec_done = 1'b0;
    push_w(64'h07000000FF7F0101, 5'd1, 1'b1);
    wait_valid(ok);
    got = {o_cmd_op, o_cmd_ext_addr, o_cmd_len, o_cmd_mem_sel, o_cmd_flags};
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      failures++;
      $display("FAIL same_cycle_done found=%b got=%h exp=%h", ok, got, e);
    end
    finish_cmd;
    push_w(64'hFF00000000000000, 5'd2, 1'b0);
    wait_halt(ok);
    checks++;
    if (!ok || o_err !== 3'b000) begin
      failures++;
      $display("FAIL b2b_end done=%b err=%b exp=1/000", ok, o_err);
    end
  endtask

  task automatic test_reset_mid;
    i_cmd_ready = 1'b0;
    start_prog;
    push_w(64'h0500000042100700, 5'd0, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_issue found=%b exp=1", ok);
    end
    sb.delete();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_cmd_valid, o_busy, o_done, o_err, o_cmd_op} !== 9'd0) begin
      failures++;
      $display("FAIL rstmid_async valid=%b busy=%b done=%b err=%b op=%0d exp=0", o_cmd_valid, o_busy, o_done, o_err, o_cmd_op);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_cmd_ready = 1'b1;
    tick;
    start_prog;
    push_w(64'h0000000000000000, 5'd0, 1'b0);
    push_w(64'hFF00000000000000, 5'd1, 1'b0);
    wait_halt(ok);
    checks++;
    if (!ok || o_err !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_rerun done=%b err=%b exp=1/000", ok, o_err);
    end
`ifdef INSTR_DECODE_STATS_EN
    checks++;
    if (o_stat_instr !== 16'd2) begin
      failures++;
      $display("FAIL rstmid_stat got=%0d exp=2", o_stat_instr);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    i_start        = 1'b0;
    i_instr        = '0;
    i_instr_addr   = '0;
    i_instr_enable = 1'b0;
    i_cmd_ready    = 1'b1;
    i_exec_done    = 1'b0;
    test_reset;
    test_basic;
    test_overflow;
    test_addr_seq;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
